sm_rocc_accel: RTL and testbench

- RoCC-style custom-instruction execute stage: accepts packed command messages, executes on a small internal accumulator register file (xfile), emits packed response messages.
- Sits directly downstream of the command unpack stage and directly upstream of the response pack stage.
- Uses val/rdy handshakes on both sides.
- Includes one multi-cycle multiply-accumulate op, so it carries a real FSM.

---
 rtl/sm_rocc_pkg.sv | 25 ++
 rtl/sm_rocc_mul_iter.sv | 78 +++++++
 rtl/sm_rocc_accel.sv | 193 +++++++++++++++++++
 tb/tb_sm_rocc_accel.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_rocc_pkg.sv
// sm_rocc_pkg: shared definitions for the sm_rocc_accel execute stage.
//   - funct codes understood by the accelerator
//   - FSM state encoding
//   - bit positions of the fields inside the 32-bit inst word
package sm_rocc_pkg;

   localparam logic [6:0] SM_ROCC_LOAD   = 7'd0;
   localparam logic [6:0] SM_ROCC_READ   = 7'd1;
   localparam logic [6:0] SM_ROCC_ACCUM  = 7'd2;
   localparam logic [6:0] SM_ROCC_MULACC = 7'd3;

   localparam int unsigned INST_W         = 32;
   localparam int unsigned INST_FUNCT_LSB = 25;
   localparam int unsigned INST_FUNCT_W   = 7;
   localparam int unsigned INST_XD_BIT    = 14;
   localparam int unsigned INST_RD_LSB    = 7;
   localparam int unsigned INST_RD_W      = 5;

   typedef enum logic [1:0] {
      SM_IDLE,
      SM_EXEC,
      SM_RESP
   } sm_state_e;

endpackage

// File: rtl/sm_rocc_mul_iter.sv
// sm_rocc_mul_iter: iterative shift-add multiplier, one multiplier bit per
// cycle for exactly p_nbits cycles after start.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : load a/b and clear the partial product (1-cycle pulse)
//   a, b         : multiplicand / multiplier, sampled on start
//   done         : 1-cycle pulse during the last iteration cycle
//   product      : low p_nbits of a*b, valid while done is high
module sm_rocc_mul_iter #(
   parameter int unsigned p_nbits = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [p_nbits-1:0] a,
   input  logic [p_nbits-1:0] b,
   output logic               done,
   output logic [p_nbits-1:0] product
);

   localparam int unsigned CW = (p_nbits > 1) ? $clog2(p_nbits) : 1;

   logic               run_q, run_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [p_nbits-1:0] a_q, a_d;
   logic [p_nbits-1:0] b_q, b_d;
   logic [p_nbits-1:0] acc_q, acc_d;
   logic [p_nbits-1:0] step_sum;
   logic               last;

   // Partial product after adding the current multiplier bit; on the last
   // cycle this is already the finished product, so the consumer can write
   // it back without waiting an extra cycle.
   assign step_sum = acc_q + (b_q[0] ? a_q : '0);
   assign last     = run_q && (cnt_q == CW'(p_nbits - 1));
   assign done     = last;
   assign product  = step_sum;

   always_comb begin
      run_d = run_q;
      cnt_d = cnt_q;
      a_d   = a_q;
      b_d   = b_q;
      acc_d = acc_q;
      if (start) begin
         run_d = 1'b1;
         cnt_d = '0;
         a_d   = a;
         b_d   = b;
         acc_d = '0;
      end else if (run_q) begin
         acc_d = step_sum;
         a_d   = a_q << 1;
         b_d   = b_q >> 1;
         if (last) begin
            run_d = 1'b0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run_q <= 1'b0;
         cnt_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
      end else begin
         run_q <= run_d;
         cnt_q <= cnt_d;
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/sm_rocc_accel.sv
// sm_rocc_accel: RoCC-style custom-instruction execute stage operating on a
// small accumulator register file (xfile).
//   clk, reset_n : clock, asynchronous active-low reset
//   cmd_msg      : {rs2, rs1, inst[31:0]}; cmd_val/cmd_rdy handshake
//   resp_msg     : {rd[4:0], data}; resp_val/resp_rdy handshake
//   busy         : high whenever the FSM is not idle
// LOAD/READ/ACCUM/other complete on the accept edge; MULACC runs through
// the iterative multiplier for p_nbits cycles before writing back.
module sm_rocc_accel
   import sm_rocc_pkg::*;
#(
   parameter int unsigned p_nbits = 32,
   parameter int unsigned p_nregs = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [2*p_nbits+31:0]  cmd_msg,
   input  logic                   cmd_val,
   output logic                   cmd_rdy,
   output logic [p_nbits+4:0]     resp_msg,
   output logic                   resp_val,
   input  logic                   resp_rdy,
   output logic                   busy
);

   localparam int unsigned IW = $clog2(p_nregs);

   // Command field extraction
   logic [INST_W-1:0]       inst;
   logic [p_nbits-1:0]      rs1, rs2;
   logic [INST_FUNCT_W-1:0] funct;
   logic                    xd;
   logic [INST_RD_W-1:0]    rd;
   logic [IW-1:0]           idx;

   assign inst  = cmd_msg[INST_W-1:0];
   assign rs1   = cmd_msg[INST_W +: p_nbits];
   assign rs2   = cmd_msg[INST_W+p_nbits +: p_nbits];
   assign funct = inst[INST_FUNCT_LSB +: INST_FUNCT_W];
   assign xd    = inst[INST_XD_BIT];
   assign rd    = inst[INST_RD_LSB +: INST_RD_W];
   assign idx   = rs2[IW-1:0];

   // irs1/irs2/xs1/xs2/opcode carry no meaning for this accelerator
   logic unused_inst;
   assign unused_inst = ^{inst[24:15], inst[13:12], inst[6:0]};

   // State
   sm_state_e            state_q, state_d;
   logic [p_nbits-1:0]   xfile_q [p_nregs];
   logic [p_nbits-1:0]   xfile_d [p_nregs];
   logic [IW-1:0]        idx_q, idx_d;
   logic [INST_RD_W-1:0] rd_q, rd_d;
   logic                 xd_q, xd_d;
   logic                 cmd_rdy_q, cmd_rdy_d;
   logic                 resp_val_q, resp_val_d;
   logic [p_nbits+4:0]   resp_msg_q, resp_msg_d;
   logic                 busy_q, busy_d;

   // Multiplier interface
   logic                 mul_start;
   logic                 mul_done;
   logic [p_nbits-1:0]   mul_product;

   sm_rocc_mul_iter #(
      .p_nbits (p_nbits)
   ) u_mul (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (mul_start),
      .a       (rs1),
      .b       (rs2),
      .done    (mul_done),
      .product (mul_product)
   );

   // Single-cycle op result, derived straight from the incoming command
   logic [p_nbits-1:0] op_data;
   logic               op_wr;
   logic [p_nbits-1:0] mac_sum;

   always_comb begin
      op_data = '0;
      op_wr   = 1'b0;
      case (funct)
         SM_ROCC_LOAD: begin
            op_data = rs1;
            op_wr   = 1'b1;
         end
         SM_ROCC_READ: begin
            op_data = xfile_q[idx];
         end
         SM_ROCC_ACCUM: begin
            op_data = xfile_q[idx] + rs1;
            op_wr   = 1'b1;
         end
         default: begin
            op_data = '0;
            op_wr   = 1'b0;
         end
      endcase
   end

   assign mac_sum = xfile_q[idx_q] + mul_product;

   always_comb begin
      state_d    = state_q;
      xfile_d    = xfile_q;
      idx_d      = idx_q;
      rd_d       = rd_q;
      xd_d       = xd_q;
      resp_msg_d = resp_msg_q;
      mul_start  = 1'b0;
      unique case (state_q)
         SM_IDLE: begin
            if (cmd_val) begin
               if (funct == SM_ROCC_MULACC) begin
                  mul_start = 1'b1;
                  idx_d     = idx;
                  rd_d      = rd;
                  xd_d      = xd;
                  state_d   = SM_EXEC;
               end else begin
                  if (op_wr) begin
                     xfile_d[idx] = op_data;
                  end
                  if (xd) begin
                     resp_msg_d = {rd, op_data};
                     state_d    = SM_RESP;
                  end
               end
            end
         end
         SM_EXEC: begin
            if (mul_done) begin
               xfile_d[idx_q] = mac_sum;
               if (xd_q) begin
                  resp_msg_d = {rd_q, mac_sum};
                  state_d    = SM_RESP;
               end else begin
                  state_d = SM_IDLE;
               end
            end
         end
         SM_RESP: begin
            if (resp_rdy) begin
               state_d = SM_IDLE;
            end
         end
         default: begin
            state_d = SM_IDLE;
         end
      endcase
      // Outputs are registered images of the next state
      cmd_rdy_d  = (state_d == SM_IDLE);
      resp_val_d = (state_d == SM_RESP);
      busy_d     = (state_d != SM_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= SM_IDLE;
         for (int unsigned i = 0; i < p_nregs; i++) begin
            xfile_q[i] <= '0;
         end
         idx_q      <= '0;
         rd_q       <= '0;
         xd_q       <= 1'b0;
         cmd_rdy_q  <= 1'b1;
         resp_val_q <= 1'b0;
         resp_msg_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         for (int unsigned i = 0; i < p_nregs; i++) begin
            xfile_q[i] <= xfile_d[i];
         end
         idx_q      <= idx_d;
         rd_q       <= rd_d;
         xd_q       <= xd_d;
         cmd_rdy_q  <= cmd_rdy_d;
         resp_val_q <= resp_val_d;
         resp_msg_q <= resp_msg_d;
         busy_q     <= busy_d;
      end
   end

   assign cmd_rdy  = cmd_rdy_q;
   assign resp_val = resp_val_q;
   assign resp_msg = resp_msg_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_sm_rocc_accel.sv
// tb_sm_rocc_accel: self-checking bench for sm_rocc_accel.
// Directed table vectors with hand-derived results, hand-written multi-cycle
// sequences (back-to-back, reset during MULACC) and random commands checked
// against an arithmetic model of the register file.
module tb_sm_rocc_accel;
   import sm_rocc_pkg::*;

   localparam int unsigned NB = 32;
   localparam int unsigned NR = 4;

   logic                clk = 1'b0;
   logic                reset_n;
   logic [2*NB+31:0]    cmd_msg;
   logic                cmd_val;
   logic                cmd_rdy;
   logic [NB+4:0]       resp_msg;
   logic                resp_val;
   logic                resp_rdy;
   logic                busy;

   always #5 clk = ~clk;

   sm_rocc_accel #(
      .p_nbits (NB),
      .p_nregs (NR)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .cmd_msg  (cmd_msg),
      .cmd_val  (cmd_val),
      .cmd_rdy  (cmd_rdy),
      .resp_msg (resp_msg),
      .resp_val (resp_val),
      .resp_rdy (resp_rdy),
      .busy     (busy)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [NB-1:0] model [NR];

   typedef struct {
      logic [6:0]    f;
      logic [NB-1:0] rs1;
      logic [NB-1:0] rs2;
      logic [4:0]    rd;
      logic          xd;
      logic [NB-1:0] exp;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: register file semantics with plain arithmetic
   function automatic logic [NB-1:0] model_exec(input logic [6:0] f,
                                                input logic [NB-1:0] rs1,
                                                input logic [NB-1:0] rs2);
      int unsigned   i;
      logic [63:0]   p;
      logic [NB-1:0] r;
      i = rs2 % NR;
      r = '0;
      case (f)
         7'd0: begin model[i] = rs1; r = rs1; end
         7'd1: r = model[i];
         7'd2: begin model[i] = model[i] + rs1; r = model[i]; end
         7'd3: begin
            p = 64'(rs1) * 64'(rs2);
            model[i] = model[i] + p[NB-1:0];
            r = model[i];
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   // Ignored inst fields are filled with random junk
   function automatic logic [2*NB+31:0] mk_cmd(input logic [6:0] f, input logic [NB-1:0] rs1,
                                              input logic [NB-1:0] rs2, input logic [4:0] rd,
                                              input logic xd);
      return {rs2, rs1, f, 10'($urandom), xd, 2'($urandom), rd, 7'($urandom)};
   endfunction

   // Issue one command (called just after a negedge) and check its response,
   // latency and handshake behaviour; hold = cycles resp_rdy stays low.
   task automatic run_cmd(input string name, input logic [6:0] f, input logic [NB-1:0] rs1,
                          input logic [NB-1:0] rs2, input logic [4:0] rd, input logic xd,
                          input int unsigned hold, output logic [NB-1:0] data);
      logic [NB-1:0] exp;
      logic [NB+4:0] msg;
      int unsigned   lat, w, exp_lat;
      w = 0;
      while (!cmd_rdy && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk({name, "/cmd_rdy_pre"}, cmd_rdy, 1);
      cmd_msg = mk_cmd(f, rs1, rs2, rd, xd);
      cmd_val = 1'b1;
      exp     = model_exec(f, rs1, rs2);
      exp_lat = (f == SM_ROCC_MULACC) ? NB + 1 : 1;
      @(negedge clk);
      cmd_val = 1'b0;
      cmd_msg = {$urandom, $urandom, $urandom};
      lat     = 1;
      data    = '0;
      if (xd) begin
         while (!resp_val && lat < 200) begin
            @(negedge clk);
            lat++;
         end
         chk({name, "/latency"}, lat, exp_lat);
         chk({name, "/resp_val"}, resp_val, 1);
         msg = resp_msg;
         chk({name, "/resp_msg"}, msg, {rd, exp});
         data = msg[NB-1:0];
         for (int unsigned h = 0; h < hold; h++) begin
            // A stray command while the response waits must be ignored
            cmd_msg = mk_cmd(SM_ROCC_LOAD, $urandom, $urandom, 5'($urandom), 1'b1);
            cmd_val = 1'b1;
            @(negedge clk);
            chk({name, "/hold_msg"}, resp_msg, msg);
            chk({name, "/hold_val"}, resp_val, 1);
            chk({name, "/hold_cmd_rdy"}, cmd_rdy, 0);
         end
         resp_rdy = 1'b1;
         @(negedge clk);
         resp_rdy = 1'b0;
         cmd_val  = 1'b0;
         chk({name, "/resp_done"}, resp_val, 0);
         chk({name, "/cmd_rdy_post"}, cmd_rdy, 1);
      end else begin
         while (busy && lat < 200) begin
            @(negedge clk);
            lat++;
         end
         chk({name, "/idle_latency"}, lat, exp_lat);
         chk({name, "/no_resp"}, resp_val, 0);
         chk({name, "/cmd_rdy_post"}, cmd_rdy, 1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [NB-1:0] d;
      logic [6:0]    rf;
      int unsigned   r;

      vecs[0]  = '{f: SM_ROCC_ACCUM,  rs1: 32'hFFFF_FFF8, rs2: 32'd2,         rd: 5'd1,  xd: 1'b1, exp: 32'h8};
      vecs[1]  = '{f: SM_ROCC_READ,   rs1: 32'h0,         rs2: 32'd6,         rd: 5'd2,  xd: 1'b1, exp: 32'h8};
      vecs[2]  = '{f: SM_ROCC_MULACC, rs1: 32'd7,         rs2: 32'd3,         rd: 5'd4,  xd: 1'b1, exp: 32'h15};
      vecs[3]  = '{f: SM_ROCC_MULACC, rs1: 32'd7,         rs2: 32'd3,         rd: 5'd4,  xd: 1'b1, exp: 32'h2A};
      vecs[4]  = '{f: 7'd9,           rs1: 32'h1234,      rs2: 32'd2,         rd: 5'd3,  xd: 1'b1, exp: 32'h0};
      vecs[5]  = '{f: SM_ROCC_MULACC, rs1: 32'd2,         rs2: 32'h105,       rd: 5'd6,  xd: 1'b0, exp: 32'h0};
      vecs[6]  = '{f: SM_ROCC_READ,   rs1: 32'h0,         rs2: 32'd0,         rd: 5'd0,  xd: 1'b1, exp: 32'h0};
      vecs[7]  = '{f: SM_ROCC_READ,   rs1: 32'h0,         rs2: 32'd1,         rd: 5'd9,  xd: 1'b1, exp: 32'h2B5};
      vecs[8]  = '{f: SM_ROCC_READ,   rs1: 32'h0,         rs2: 32'd2,         rd: 5'd10, xd: 1'b1, exp: 32'h8};
      vecs[9]  = '{f: SM_ROCC_READ,   rs1: 32'h0,         rs2: 32'd3,         rd: 5'd31, xd: 1'b1, exp: 32'h2A};
      vecs[10] = '{f: SM_ROCC_ACCUM,  rs1: 32'd1,         rs2: 32'hFFFF_FFFC, rd: 5'd12, xd: 1'b0, exp: 32'h0};
      vecs[11] = '{f: SM_ROCC_READ,   rs1: 32'h0,         rs2: 32'd4,         rd: 5'd17, xd: 1'b1, exp: 32'h1};

      for (int i = 0; i < NR; i++) model[i] = '0;
      reset_n  = 1'b0;
      cmd_val  = 1'b0;
      resp_rdy = 1'b0;
      cmd_msg  = '0;
      repeat (3) @(negedge clk);
      chk("reset/cmd_rdy", cmd_rdy, 1);
      chk("reset/resp_val", resp_val, 0);
      chk("reset/resp_msg", resp_msg, 0);
      chk("reset/busy", busy, 0);
      reset_n = 1'b1;
      @(negedge clk);

      // LOAD with response held back for three cycles
      run_cmd("t1_load", SM_ROCC_LOAD, 32'h10, 32'd2, 5'd5, 1'b1, 3, d);
      chk("t1_load/data", d, 32'h10);

      // LOAD xd=0 immediately followed by READ of the same entry
      cmd_msg = mk_cmd(SM_ROCC_LOAD, 32'hAB, 32'd1, 5'd8, 1'b0);
      cmd_val = 1'b1;
      void'(model_exec(SM_ROCC_LOAD, 32'hAB, 32'd1));
      @(negedge clk);
      chk("b2b/cmd_rdy", cmd_rdy, 1);
      chk("b2b/no_resp", resp_val, 0);
      cmd_msg = mk_cmd(SM_ROCC_READ, 32'h0, 32'd1, 5'd7, 1'b1);
      void'(model_exec(SM_ROCC_READ, 32'h0, 32'd1));
      @(negedge clk);
      cmd_val = 1'b0;
      chk("b2b/resp_val", resp_val, 1);
      chk("b2b/resp_msg", resp_msg, {5'd7, 32'hAB});
      resp_rdy = 1'b1;
      @(negedge clk);
      resp_rdy = 1'b0;
      chk("b2b/resp_done", resp_val, 0);

      for (int i = 0; i < 12; i++) begin
         run_cmd($sformatf("vec%0d", i), vecs[i].f, vecs[i].rs1, vecs[i].rs2,
                 vecs[i].rd, vecs[i].xd, i % 3, d);
         if (vecs[i].xd) chk($sformatf("vec%0d/data", i), d, vecs[i].exp);
      end

      // Reset in the middle of a MULACC discards it
      cmd_msg = mk_cmd(SM_ROCC_MULACC, 32'd5, 32'd3, 5'd2, 1'b1);
      cmd_val = 1'b1;
      @(negedge clk);
      cmd_val = 1'b0;
      repeat (9) @(negedge clk);
      chk("rst_exec/busy_pre", busy, 1);
      reset_n = 1'b0;
      #1;
      chk("rst_exec/busy", busy, 0);
      chk("rst_exec/cmd_rdy", cmd_rdy, 1);
      chk("rst_exec/resp_val", resp_val, 0);
      for (int i = 0; i < NR; i++) model[i] = '0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_exec/no_resp", resp_val, 0);
      run_cmd("rst_exec/read3", SM_ROCC_READ, 32'h0, 32'd3, 5'd3, 1'b1, 0, d);
      chk("rst_exec/read3_data", d, 32'h0);
      run_cmd("rst_exec/read1", SM_ROCC_READ, 32'h0, 32'd1, 5'd1, 1'b1, 0, d);
      chk("rst_exec/read1_data", d, 32'h0);

      // Random commands against the model
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 5);
         if (r < 4)       rf = 7'(r);
         else if (r == 4) rf = SM_ROCC_READ;
         else             rf = 7'($urandom_range(4, 127));
         run_cmd($sformatf("rnd%0d", i), rf, $urandom, $urandom, 5'($urandom),
                 ($urandom_range(0, 3) != 0), $urandom_range(0, 2), d);
      end

      // Final sweep of every entry
      for (int i = 0; i < NR; i++) begin
         run_cmd($sformatf("final%0d", i), SM_ROCC_READ, $urandom, 32'(i), 5'(i), 1'b1, 0, d);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
